pipe_ctrl: RTL and testbench

//  Parametrised N-stage in-order pipeline controller for the core. It replaces the per-register

---
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl
// ----------------------------------------------------------------------------
// In-order pipeline controller. It owns the per-stage valid bits and drives
// the load enables of the NSTAGE pipeline registers in the datapath. It
// resolves back-pressure from stall requests and kills younger stages when an
// older stage redirects the PC. It also keeps the cycle and retired-instruction
// counters and a watchdog on stage 0 hold time.
//
// Stage 0 is the youngest register (IF/ID). Stage NSTAGE-1 is the oldest
// (MEM/WB).
//
// Parameters
//   NSTAGE  number of controlled pipeline registers (>= 2)
//   XLEN    PC / counter width
//   WDOG    consecutive stage-0 hold cycles before wdog_timeout (>= 1)
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous reset, active low
//   in_valid        fetch offers an instruction to stage 0
//   in_ready        stage 0 accepts this cycle
//   stall_req       per-stage "cannot advance" request
//   flush_req       per-stage redirect request (one-cycle pulse)
//   flush_pc        per-stage redirect target, slice [i*XLEN +: XLEN]
//   stage_valid     registered per-stage live-instruction flags
//   stage_en        per-stage register load enable for this cycle
//   redirect_valid  PC must load redirect_pc this cycle
//   redirect_pc     target of the oldest live redirecting stage
//   commit_valid    oldest stage retires this cycle
//   cycle_cnt       cycles since reset (wraps)
//   instret_cnt     retired instructions since reset (wraps)
//   wdog_timeout    sticky flag: stage 0 held for WDOG consecutive cycles
// ============================================================================
module pipe_ctrl #(
    parameter int NSTAGE = 5,
    parameter int XLEN   = 64,
    parameter int WDOG   = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NSTAGE-1:0]        stall_req,
    input  logic [NSTAGE-1:0]        flush_req,
    input  logic [NSTAGE*XLEN-1:0]   flush_pc,
    output logic [NSTAGE-1:0]        stage_valid,
    output logic [NSTAGE-1:0]        stage_en,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     commit_valid,
    output logic [XLEN-1:0]          cycle_cnt,
    output logic [XLEN-1:0]          instret_cnt,
    output logic                     wdog_timeout
);

    // Watchdog counter is wide enough to hold WDOG-1. A 1-bit counter is
    // kept for WDOG == 1 so the width never collapses to zero.
    localparam int              WCW      = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam logic [WCW-1:0]  WDOG_MAX = WCW'(WDOG - 1);

    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] eff_flush;
    logic [NSTAGE-1:0] kill;
    logic [NSTAGE-1:0] valid_nxt;
    logic [WCW-1:0]    wdog_cnt;

    // Back-pressure: a stall in stage i freezes stage i and every younger
    // stage. The running OR is accumulated from the oldest stage downward.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc     = acc | stall_req[i];
            hold[i] = acc;
        end
    end

    // Redirect resolution. Only a live stage may redirect. The oldest live
    // requester wins. kill[i] is set when any effective flush sits strictly
    // above i, so the winner survives and every younger stage is squashed.
    always_comb begin
        logic acc;
        eff_flush   = flush_req & stage_valid;
        acc         = 1'b0;
        kill        = '0;
        redirect_pc = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            kill[i] = acc;
            acc     = acc | eff_flush[i];
        end
        // Ascending scan: the last (oldest) hit overwrites younger ones.
        for (int i = 0; i < NSTAGE; i++) begin
            if (eff_flush[i]) begin
                redirect_pc = flush_pc[i*XLEN +: XLEN];
            end
        end
    end

    assign redirect_valid = |eff_flush;

    // Fetch is refused while stage 0 is frozen or while the PC is being
    // redirected. An offer made during a redirect is simply dropped.
    assign in_ready     = ~hold[0] & ~redirect_valid;
    assign stage_en     = ~hold | kill;
    assign commit_valid = stage_valid[NSTAGE-1] & ~stall_req[NSTAGE-1];

    // Next-state valid bits. Priority is kill, then hold, then advance. A
    // stage directly above a frozen stage receives a bubble.
    always_comb begin
        valid_nxt = '0;
        if (kill[0]) begin
            valid_nxt[0] = 1'b0;
        end else if (hold[0]) begin
            valid_nxt[0] = stage_valid[0];
        end else begin
            valid_nxt[0] = in_valid & in_ready;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            if (kill[i]) begin
                valid_nxt[i] = 1'b0;
            end else if (hold[i]) begin
                valid_nxt[i] = stage_valid[i];
            end else if (hold[i-1]) begin
                valid_nxt[i] = 1'b0;
            end else begin
                valid_nxt[i] = stage_valid[i-1];
            end
        end
    end

    // State registers: valids, counters and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid  <= '0;
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
        end else begin
            stage_valid <= valid_nxt;
            cycle_cnt   <= cycle_cnt + XLEN'(1);
            instret_cnt <= instret_cnt + XLEN'(commit_valid);
            if (hold[0]) begin
                // Saturate so a very long stall cannot wrap back to zero.
                if (wdog_cnt != WDOG_MAX) begin
                    wdog_cnt <= wdog_cnt + WCW'(1);
                end
                if (wdog_cnt == WDOG_MAX) begin
                    wdog_timeout <= 1'b1;
                end
            end else begin
                wdog_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for pipe_ctrl. The driver issues one cycle of stimulus at a
// time. It computes the expected outputs from a reference model that tracks
// instruction tags per stage, then queues them. A separate monitor pops each
// expectation and compares it with the DUT outputs for that cycle.
// ============================================================================
module tb_pipe_ctrl;

    localparam int NSTAGE = 5;
    localparam int XLEN   = 32;
    localparam int WDOG   = 4;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [NSTAGE-1:0]      stall_req;
    logic [NSTAGE-1:0]      flush_req;
    logic [NSTAGE*XLEN-1:0] flush_pc;
    logic [NSTAGE-1:0]      stage_valid;
    logic [NSTAGE-1:0]      stage_en;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   commit_valid;
    logic [XLEN-1:0]        cycle_cnt;
    logic [XLEN-1:0]        instret_cnt;
    logic                   wdog_timeout;

    pipe_ctrl #(.NSTAGE(NSTAGE), .XLEN(XLEN), .WDOG(WDOG)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .stage_valid    (stage_valid),
        .stage_en       (stage_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .commit_valid   (commit_valid),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt),
        .wdog_timeout   (wdog_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              in_ready;
        logic              rv;
        logic [XLEN-1:0]   rpc;
        logic              commit;
        logic [NSTAGE-1:0] en;
        logic [NSTAGE-1:0] valid;
        logic [XLEN-1:0]   cyc;
        logic [XLEN-1:0]   inst;
        logic              tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model. Each stage holds an instruction tag (0 = empty).
    int              pipe[NSTAGE];
    int              next_id = 1;
    logic [XLEN-1:0] m_cyc;
    logic [XLEN-1:0] m_inst;
    int              run;
    bit              m_tmo;
    int              accepted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSTAGE; i++) pipe[i] = 0;
        m_cyc    = '0;
        m_inst   = '0;
        run      = 0;
        m_tmo    = 0;
        accepted = 0;
    endtask

    // Drive one cycle of inputs, predict the outputs, and advance the model.
    task automatic drive(input bit iv, input logic [NSTAGE-1:0] st,
                         input logic [NSTAGE-1:0] fl, input logic [NSTAGE*XLEN-1:0] fp);
        exp_t e;
        int   s;
        int   w;
        int   np[NSTAGE];
        @(negedge clk);
        in_valid  = iv;
        stall_req = st;
        flush_req = fl;
        flush_pc  = fp;

        s = -1;                                  // oldest stalled stage
        for (int i = 0; i < NSTAGE; i++) if (st[i]) s = i;
        w = -1;                                  // oldest live redirecting stage
        for (int i = 0; i < NSTAGE; i++) if (fl[i] && pipe[i] != 0) w = i;

        e.rv       = (w >= 0);
        e.rpc      = (w >= 0) ? fp[w*XLEN +: XLEN] : '0;
        e.in_ready = (s < 0) && (w < 0);
        e.commit   = (pipe[NSTAGE-1] != 0) && !st[NSTAGE-1];
        for (int i = 0; i < NSTAGE; i++) begin
            e.en[i]    = (i > s) || (i < w);
            e.valid[i] = (pipe[i] != 0);
        end
        e.cyc  = m_cyc;
        e.inst = m_inst;
        e.tmo  = m_tmo;
        sb.push_back(e);

        for (int i = 0; i < NSTAGE; i++) begin
            if (i < w)        np[i] = 0;
            else if (i <= s)  np[i] = pipe[i];
            else if (i == 0) begin
                if (iv && e.in_ready) begin
                    np[i] = next_id;
                    next_id++;
                    accepted++;
                end else begin
                    np[i] = 0;
                end
            end
            else if (i - 1 <= s) np[i] = 0;
            else                 np[i] = pipe[i-1];
        end
        for (int i = 0; i < NSTAGE; i++) pipe[i] = np[i];
        m_cyc  = m_cyc + 1;
        if (e.commit) m_inst = m_inst + 1;
        if (s >= 0) run++; else run = 0;
        if (run >= WDOG) m_tmo = 1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"},   stage_valid,    0);
        chk({tag, "_cycle"},   cycle_cnt,      0);
        chk({tag, "_instret"}, instret_cnt,    0);
        chk({tag, "_wdog"},    wdog_timeout,   0);
        chk({tag, "_ready"},   in_ready,       1);
        chk({tag, "_commit"},  commit_valid,   0);
        chk({tag, "_redir"},   redirect_valid, 0);
    endtask

    // Assert reset off-edge, check state cleared at once, release off-edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #3;
        reset     = 1'b0;
        in_valid  = 1'b0;
        stall_req = '0;
        flush_req = '0;
        flush_pc  = '0;
        #1;
        reset_checks(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic first_commit_run(input string tag, input int ncyc);
        int first;
        first = -1;
        for (int k = 0; k < ncyc; k++) begin
            drive(1'b1, '0, '0, '0);
            #1;
            if (first < 0 && commit_valid) first = k;
        end
        chk(tag, first, 5);
    endtask

    // Monitor: compare every cycle's outputs with the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("in_ready",       in_ready,       mon_e.in_ready);
                chk("redirect_valid", redirect_valid, mon_e.rv);
                chk("redirect_pc",    redirect_pc,    mon_e.rpc);
                chk("commit_valid",   commit_valid,   mon_e.commit);
                chk("stage_en",       stage_en,       mon_e.en);
                chk("stage_valid",    stage_valid,    mon_e.valid);
                chk("cycle_cnt",      cycle_cnt,      mon_e.cyc);
                chk("instret_cnt",    instret_cnt,    mon_e.inst);
                chk("wdog_timeout",   wdog_timeout,   mon_e.tmo);
            end
        end
    end

    initial begin
        logic [NSTAGE*XLEN-1:0] fp;
        logic [NSTAGE-1:0]      st;
        logic [NSTAGE-1:0]      fl;
        bit                     iv;

        reset     = 1'b0;
        in_valid  = 1'b0;
        stall_req = '0;
        flush_req = '0;
        flush_pc  = '0;
        model_reset();
        #1;
        reset_checks("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming with no stalls.
        first_commit_run("t1_first_commit", 20);

        // Stall in stage 3 with a full pipe.
        do_reset("t2_rst");
        for (int k = 0; k < 6; k++) drive(1'b1, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'b01000, '0, '0);
            #1;
            chk("t2_en_low", stage_en[3:0], 0);
            chk("t2_ready",  in_ready,      0);
        end
        for (int k = 0; k < 8; k++) drive(1'b1, '0, '0, '0);
        for (int k = 0; k < 8; k++) drive(1'b0, '0, '0, '0);
        #1;
        chk("t2_conserve", 64'(instret_cnt) + 64'($countones(stage_valid)), 64'(accepted));

        // Two simultaneous flushes: the oldest one wins.
        do_reset("t3_rst");
        for (int k = 0; k < 6; k++) drive(1'b1, '0, '0, '0);
        fp = '0;
        fp[3*XLEN +: XLEN] = 32'h8000_0100;
        fp[2*XLEN +: XLEN] = 32'h1111_0000;
        drive(1'b1, '0, 5'b01100, fp);
        #1;
        chk("t3_redir_pc",    redirect_pc,    32'h8000_0100);
        chk("t3_redir_valid", redirect_valid, 1);
        drive(1'b1, '0, '0, '0);
        #1;
        chk("t3_valid_after", stage_valid[2:0], 0);

        // Flush from an empty stage is ignored.
        fp = '0;
        fp[1*XLEN +: XLEN] = 32'hDEAD_BEEF;
        drive(1'b1, '0, 5'b00010, fp);
        #1;
        chk("t4_no_redirect", redirect_valid, 0);
        chk("t4_ready",       in_ready,       1);
        for (int k = 0; k < 4; k++) drive(1'b1, '0, '0, '0);

        // Watchdog: stage 0 held for WDOG cycles, then released.
        do_reset("t5_rst");
        for (int k = 0; k < WDOG; k++) begin
            drive(1'b0, 5'b00001, '0, '0);
            #1;
            chk("t5_wdog_early", wdog_timeout, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, '0, '0, '0);
            #1;
            chk("t5_wdog_sticky", wdog_timeout, 1);
        end

        // Randomized traffic.
        do_reset("rnd_rst");
        for (int k = 0; k < 400; k++) begin
            iv = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NSTAGE; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                fl[i] = ($urandom_range(0, 9) == 0);
                fp[i*XLEN +: XLEN] = $urandom;
            end
            drive(iv, st, fl, fp);
        end

        // Reset in the middle of traffic, then refill.
        do_reset("t6_rst");
        first_commit_run("t6_first_commit", 10);

        for (int k = 0; k < 3; k++) drive(1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
